apb_mem_bridge: RTL
===================

APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

Interface
REQ-001 SHALL have parameter EXTRA_WAIT, default 0, meaning extra wait cycles (0..7) inserted before PREADY.
REQ-002 SHALL have parameter ADDR_LIMIT, default 255, meaning the highest legal address; above it is an error.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  1=write, 0=read.
REQ-008 SHALL have port paddr  input  8  APB address.
REQ-009 SHALL have port pwdata  input  8  APB write data.
REQ-010 SHALL have port prdata  output  8  APB read data, registered.
REQ-011 SHALL have port pready  output  1  transfer complete, registered.
REQ-012 SHALL have port pslverr  output  1  error response, valid only with pready.
REQ-013 SHALL have port mem_addr  output  8  address to the downstream synchronous memory.
REQ-014 SHALL have port mem_ce  output  1  memory chip enable.
REQ-015 SHALL have port mem_wren  output  1  memory write enable.
REQ-016 SHALL have port mem_rden  output  1  memory read enable; read has priority in memory.
REQ-017 SHALL have port mem_wr_data  output  8  memory write data.
REQ-018 SHALL have port mem_rd_data  input  8  memory read data, valid one clk after the rden strobe.

Function
REQ-019 SHALL implement FSM states IDLE, STROBE, LATCH, WAIT, DONE.
REQ-020 In IDLE, psel=1 and penable=0 sampled: latch paddr->mem_addr, pwdata->mem_wr_data, pwrite, error flag (paddr>ADDR_LIMIT); go to STROBE.
REQ-021 In IDLE, penable=1 without a prior setup SHALL be ignored.
REQ-022 STROBE (one cycle): if no error, mem_ce=1, with mem_rden=~pwrite and mem_wren=pwrite; if error, all strobes 0; go to LATCH.
REQ-023 Strobes SHALL never be high outside STROBE, and mem_rden and mem_wren SHALL never both be 1.
REQ-024 LATCH: on a read without error, prdata SHALL load mem_rd_data at the end of the cycle.
REQ-025 From LATCH the FSM SHALL go to DONE if EXTRA_WAIT=0, else to WAIT with a counter loaded with EXTRA_WAIT-1.
REQ-026 WAIT: decrement the counter each cycle; go to DONE when the counter is 0.
REQ-027 DONE (one cycle): pready=1, pslverr=error flag; go to IDLE.
REQ-028 Latency SHALL be setup cycle + 3+EXTRA_WAIT access cycles, i.e. pready high in the 3rd+EXTRA_WAIT cycle with penable=1.
REQ-029 prdata SHALL hold its last read value across writes, errored transfers, and idle.
REQ-030 On an error, pslverr=1, no memory access, and prdata unchanged.
REQ-031 If psel=0 is sampled in STROBE/LATCH/WAIT, the FSM SHALL return to IDLE with no pready; a write already strobed remains committed.
REQ-032 Back-to-back: a setup phase in the cycle after DONE SHALL be accepted with no idle gap.
REQ-033 Addresses 0 and 255 SHALL be legal when ADDR_LIMIT=255; no address wrap or arithmetic is applied.

Reset
REQ-034 rst=1 SHALL asynchronously force state IDLE, counter 0, error flag 0, and all outputs (prdata, pready, pslverr, mem_*) to 0.
REQ-035 rst asserted mid-transfer SHALL drop strobes immediately; the transfer is lost; after rst falls, the next setup SHALL be accepted normally.

Verification
REQ-036 Write paddr=0x10, pwdata=0xA5, EXTRA_WAIT=0 -> one-cycle mem_ce=mem_wren=1, mem_addr=0x10; pready at 3rd access cycle; pslverr=0.
REQ-037 Read 0x10 after REQ-036 write -> mem_rden one cycle; prdata=0xA5 with pready; back-to-back read of 0xFF accepted with no gap.
REQ-038 ADDR_LIMIT=0x7F, write 0x80 -> no strobes, pready with pslverr=1; subsequent read 0x80 -> pslverr=1, prdata unchanged.
REQ-039 EXTRA_WAIT=3, read 0x00 -> pready exactly 6 access cycles after setup; counter returns to IDLE cleanly.
REQ-040 rst pulse during LATCH of a read -> prdata=0, pready=0, state IDLE immediately; next write 0x01/0x3C completes normally.
REQ-041 psel dropped during WAIT -> no pready, FSM in IDLE next cycle, next transfer correct.

Source files
------------

// File: rtl/apb_mem_bridge_if.sv
// APB slave bus bundled with the downstream synchronous memory port.
// The bridge uses the slave view; the driving/monitoring side uses the master view.
interface apb_mem_bridge_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] mem_addr;
  logic       mem_ce;
  logic       mem_wren;
  logic       mem_rden;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, mem_rd_data,
    output prdata, pready, pslverr, mem_addr, mem_ce, mem_wren, mem_rden, mem_wr_data
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, mem_rd_data,
    input  prdata, pready, pslverr, mem_addr, mem_ce, mem_wren, mem_rden, mem_wr_data
  );
endinterface

// File: rtl/apb_mem_bridge.sv
// APB slave to single-port synchronous memory bridge: one-cycle strobe,
// latched read data, optional wait states, and an address-range error.
module apb_mem_bridge #(
  parameter int EXTRA_WAIT = 0,
  parameter int ADDR_LIMIT = 255
) (
  input logic              clk,
  input logic              rst,
  apb_mem_bridge_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, STROBE, LATCH, WAIT, DONE} state_e;

  localparam logic [8:0] LIMIT     = 9'(ADDR_LIMIT);
  localparam logic [2:0] WAIT_LOAD = 3'((EXTRA_WAIT > 0) ? EXTRA_WAIT - 1 : 0);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A lone penable with no preceding setup phase is not a transfer.
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          wdata_d = bus.pwdata;
          wr_d    = bus.pwrite;
          err_d   = ({1'b0, bus.paddr} > LIMIT);
          state_d = STROBE;
        end
      end
      STROBE: state_d = bus.psel ? LATCH : IDLE;
      LATCH: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else begin
          if (!wr_q && !err_q) prdata_d = bus.mem_rd_data;
          if (EXTRA_WAIT == 0) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = err_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign bus.mem_ce      = (state_q == STROBE) && !err_q;
  assign bus.mem_wren    = bus.mem_ce && wr_q;
  assign bus.mem_rden    = bus.mem_ce && !wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.prdata      = prdata_q;
  assign bus.pready      = pready_q;
  assign bus.pslverr     = pslverr_q;
endmodule
